button_irq_src: RTL and testbench
=================================

BUTTON_IRQ_SRC -- requirements
Module: button_irq_src

Interface
REQ-001 Parameter DB_CYCLES, default 1000000, is the number of consecutive stable cycles needed to accept a new button level (10 ms at 100 MHz); legal range is 2..2^20.
REQ-002 Port clk, input, 1 bit: system clock (100 MHz), the same clock as the pipeline controller.
REQ-003 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 Ports btn_u_raw, btn_d_raw, btn_l_raw, btn_r_raw, btn_c_raw, input, 1 bit each: raw, asynchronous, bouncing board buttons.
REQ-005 Port irq_done, input, 1 bit: level-high when the interrupt handler has finished (mipd == 1).
REQ-006 Ports butu, butd, butl, butr, butc, output, 1 bit each: registered one-cycle request pulses, driving the controller's button inputs.
REQ-007 Port btn_code, output, 3 bits: code of the last issued request (u=1, d=2, l=3, r=4, c=5); 0 after reset.
REQ-008 Port busy, output, 1 bit: high from request issue until handler done and buttons released.
REQ-009 Port dropped, output, 1 bit: one-cycle pulse when a press is discarded.

Function
REQ-010 Each raw input shall pass a 2-flop synchronizer before any other use.
REQ-011 Each button shall have a counter of 20 bits or more. The counter increments while the synced value differs from the debounced level db, and clears to 0 whenever they match.
REQ-012 When the counter equals DB_CYCLES-1 and still mismatches, db shall toggle on the next edge and the counter shall clear.
REQ-013 A press event is db rising (db=1 and db_q=0, where db_q is db delayed one cycle); db falling produces no event.
REQ-014 With a raw input stable high from sampling edge k, the matching but* pulse shall be high in exactly the cycle after edge k+DB_CYCLES+3 (FSM idle, no other press).
REQ-015 A glitch shorter than DB_CYCLES synced cycles shall not change db.
REQ-016 FSM states:
- IDLE: all pulses low, busy=0.
- ISSUE: exactly one but* high for one cycle; btn_code updated; busy=1.
- WAIT_DONE: busy=1.
- RELEASE: busy=1.
REQ-017 The FSM shall go IDLE -> ISSUE on any press event; ISSUE -> WAIT_DONE unconditionally.
REQ-018 The FSM shall go WAIT_DONE -> RELEASE when irq_done=1; RELEASE -> IDLE when all five db are 0; otherwise it holds.
REQ-019 When several press events occur in the same cycle, priority shall be u > d > l > r > c; only the winner is issued and the losers are discarded without a dropped pulse.
REQ-020 A press event in ISSUE, WAIT_DONE or RELEASE shall be handled per REQ-026/REQ-027.
REQ-021 irq_done while IDLE or ISSUE shall be ignored.
REQ-022 The but* outputs shall be mutually exclusive in every cycle, and shall never be high for two consecutive cycles.

Reset
REQ-023 Asserting rst at any time, including mid-debounce or mid-request, shall immediately force the following: FSM=IDLE, all but*=0, btn_code=0, busy=0, dropped=0, all counters=0, all db/db_q/synchronizer flops=0, pending cleared.
REQ-024 After rst deasserts, a button already held high shall produce a press event after DB_CYCLES+3 cycles.

Configuration
REQ-025 The macro BTN_PENDING_EN compiles in a one-entry pending slot.
REQ-026 With BTN_PENDING_EN defined: the first (highest-priority) press event while busy is stored in the slot. Further events while the slot is full pulse dropped. On RELEASE -> IDLE with the slot full, the FSM goes directly to ISSUE for the stored button next cycle and clears the slot. The RELEASE exit condition ignores the stored button's db.
REQ-027 Without BTN_PENDING_EN: every press event while busy pulses dropped and is discarded; no slot logic exists.

Verification
REQ-028 Scenario "single press": DB_CYCLES=4, btn_u_raw high from edge 10 -> butu high only in the cycle after edge 17, btn_code=1, busy=1; irq_done=1 then release -> busy=0.
REQ-029 Scenario "bounce": DB_CYCLES=4, btn_c_raw toggled every 2 cycles for 20 cycles then held low -> no pulse, dropped never high.
REQ-030 Scenario "simultaneous press": btn_l_raw and btn_r_raw rise on the same edge -> only butl pulses, btn_code=3; butr never pulses.
REQ-031 Scenario "busy press": btn_d press during WAIT_DONE -> with BTN_PENDING_EN, butd is issued after the handler done and release, and dropped=0; without the macro, dropped pulses once and butd never pulses.
REQ-032 Scenario "reset mid-request": rst asserted in WAIT_DONE with btn_u held -> outputs zero the same cycle; after release of rst, butu pulses again DB_CYCLES+3 cycles later.
REQ-033 Scenario "stuck button": btn_r held through irq_done -> FSM stays in RELEASE with busy=1 and no new butr pulse until btn_r is released.

Source files
------------

// File: rtl/button_irq_src_if.sv
// Button request bundle between the debouncer/request source and the pipeline controller.
// slave = the button_irq_src side, master = the controller/board side.
interface button_irq_src_if;
    logic       btn_u_raw;
    logic       btn_d_raw;
    logic       btn_l_raw;
    logic       btn_r_raw;
    logic       btn_c_raw;
    logic       irq_done;
    logic       butu;
    logic       butd;
    logic       butl;
    logic       butr;
    logic       butc;
    logic [2:0] btn_code;
    logic       busy;
    logic       dropped;

    modport master (
        output btn_u_raw, btn_d_raw, btn_l_raw, btn_r_raw, btn_c_raw, irq_done,
        input  butu, butd, butl, butr, butc, btn_code, busy, dropped
    );

    modport slave (
        input  btn_u_raw, btn_d_raw, btn_l_raw, btn_r_raw, btn_c_raw, irq_done,
        output butu, butd, butl, butr, butc, btn_code, busy, dropped
    );
endinterface

// File: rtl/button_irq_src.sv
// Debounces five board buttons and turns presses into one-cycle requests to the pipeline controller.
// Define BTN_PENDING_EN to keep one press that arrives while a request is in flight.
module button_irq_src #(
    parameter int unsigned DB_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    button_irq_src_if.slave  bus
);
    localparam int CW = 20;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, RELEASE} state_t;

    // Bit order everywhere: 0=u, 1=d, 2=l, 3=r, 4=c (lowest index has priority)
    logic [4:0]    raw;
    logic [4:0]    sync_p0, sync_p1;
    logic [4:0]    db_p2, db_p3;
    logic [4:0]    ev_p3;
    logic [CW-1:0] cnt [5];

    state_t        state;
    logic [4:0]    pulse;
    logic [2:0]    code;
    logic          busy_r;
    logic          drop_r;
    logic [4:0]    win;
    logic [4:0]    held;
`ifdef BTN_PENDING_EN
    logic [4:0]    pend;
`endif

    function automatic logic [4:0] first_hit(input logic [4:0] v);
        for (int i = 0; i < 5; i++) begin
            if (v[i]) return 5'(1 << i);
        end
        return '0;
    endfunction

    function automatic logic [2:0] code_of(input logic [4:0] onehot);
        for (int i = 0; i < 5; i++) begin
            if (onehot[i]) return 3'(i + 1);
        end
        return '0;
    endfunction

    assign raw = {bus.btn_c_raw, bus.btn_r_raw, bus.btn_l_raw, bus.btn_d_raw, bus.btn_u_raw};

    // p0/p1: synchronizer, p2: debounced level, p3: registered rising-edge event
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            db_p2   <= '0;
            db_p3   <= '0;
            ev_p3   <= '0;
            for (int i = 0; i < 5; i++) cnt[i] <= '0;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
            db_p3   <= db_p2;
            ev_p3   <= db_p2 & ~db_p3;
            for (int i = 0; i < 5; i++) begin
                if (sync_p1[i] == db_p2[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    cnt[i]   <= '0;
                    db_p2[i] <= ~db_p2[i];
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // A stored press is still physically held when it finally gets issued, so it must not block release.
    always_comb begin
        win = first_hit(ev_p3);
`ifdef BTN_PENDING_EN
        held = db_p2 & ~pend;
`else
        held = db_p2;
`endif
    end

    // Request FSM: outputs are registered alongside the state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            pulse  <= '0;
            code   <= '0;
            busy_r <= 1'b0;
            drop_r <= 1'b0;
`ifdef BTN_PENDING_EN
            pend   <= '0;
`endif
        end else begin
            pulse  <= '0;
            drop_r <= 1'b0;
            case (state)
                IDLE: begin
`ifdef BTN_PENDING_EN
                    if (|pend) begin
                        state  <= ISSUE;
                        pulse  <= pend;
                        code   <= code_of(pend);
                        busy_r <= 1'b1;
                        pend   <= '0;
                    end else
`endif
                    if (|win) begin
                        state  <= ISSUE;
                        pulse  <= win;
                        code   <= code_of(win);
                        busy_r <= 1'b1;
                    end
                end
                ISSUE: state <= WAIT_DONE;
                WAIT_DONE: begin
                    if (bus.irq_done) state <= RELEASE;
                end
                RELEASE: begin
                    if (held == '0) begin
`ifdef BTN_PENDING_EN
                        if (|pend) begin
                            state <= ISSUE;
                            pulse <= pend;
                            code  <= code_of(pend);
                            pend  <= '0;
                        end else begin
                            state  <= IDLE;
                            busy_r <= 1'b0;
                        end
`else
                        state  <= IDLE;
                        busy_r <= 1'b0;
`endif
                    end
                end
                default: state <= IDLE;
            endcase

            if (state != IDLE && |win) begin
`ifdef BTN_PENDING_EN
                if (pend == '0) pend <= win;
                else            drop_r <= 1'b1;
`else
                drop_r <= 1'b1;
`endif
            end
        end
    end

    assign bus.butu     = pulse[0];
    assign bus.butd     = pulse[1];
    assign bus.butl     = pulse[2];
    assign bus.butr     = pulse[3];
    assign bus.butc     = pulse[4];
    assign bus.btn_code = code;
    assign bus.busy     = busy_r;
    assign bus.dropped  = drop_r;
endmodule

// File: tb/tb_button_irq_src.sv
// Bench for button_irq_src: a press/request model checked every cycle plus directed scenarios.
// Build with or without BTN_PENDING_EN; expectations follow the macro.
module tb_button_irq_src;
    localparam int DB = 4;
`ifdef BTN_PENDING_EN
    localparam bit PEND = 1'b1;
`else
    localparam bit PEND = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    button_irq_src_if bus();
    button_irq_src #(.DB_CYCLES(DB)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int edge_n = 0;
    int pcnt [5];
    int last_edge [5];
    int dcnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: level accepted after DB consecutive opposite samples; a rise becomes a request
    // two edges later; one request in flight at a time.
    bit [4:0] m_raw1, m_raw2, m_db, m_rise1, m_rise2, m_pulse, m_pend;
    int       m_run [5];
    bit       m_busy, m_drop, m_done_seen, m_fresh;
    bit [2:0] m_code;

    function automatic bit [4:0] first_of(input bit [4:0] v);
        for (int i = 0; i < 5; i++) if (v[i]) return 5'(1 << i);
        return '0;
    endfunction

    function automatic bit [2:0] code_of(input bit [4:0] oh);
        for (int i = 0; i < 5; i++) if (oh[i]) return 3'(i + 1);
        return '0;
    endfunction

    task automatic m_issue(input bit [4:0] oh);
        m_pulse     = oh;
        m_code      = code_of(oh);
        m_busy      = 1'b1;
        m_fresh     = 1'b1;
        m_done_seen = 1'b0;
    endtask

    always @(posedge clk or posedge rst) begin : model
        bit [4:0] ev, win, old_pend, hold, syn, ndb, rawv;
        if (rst) begin
            m_raw1 = '0; m_raw2 = '0; m_db = '0; m_rise1 = '0; m_rise2 = '0;
            m_pulse = '0; m_pend = '0; m_busy = 0; m_drop = 0; m_done_seen = 0;
            m_fresh = 0; m_code = '0;
            for (int i = 0; i < 5; i++) m_run[i] = 0;
        end else begin
            rawv = {bus.btn_c_raw, bus.btn_r_raw, bus.btn_l_raw, bus.btn_d_raw, bus.btn_u_raw};
            ev = m_rise2;
            win = first_of(ev);
            old_pend = m_pend;
            hold = m_db & ~old_pend;
            m_pulse = '0;
            m_drop = 1'b0;
            if (!m_busy) begin
                if (old_pend != 0) begin
                    m_issue(old_pend);
                    m_pend = '0;
                end else if (win != 0) begin
                    m_issue(win);
                end
            end else begin
                if (win != 0) begin
                    if (PEND && old_pend == 0) m_pend = win;
                    else m_drop = 1'b1;
                end
                if (m_fresh) m_fresh = 1'b0;
                else if (!m_done_seen) m_done_seen = bus.irq_done;
                else if (hold == 0) begin
                    if (old_pend != 0) begin
                        m_issue(old_pend);
                        m_pend = '0;
                    end else begin
                        m_busy = 1'b0;
                    end
                end
            end
            syn = m_raw2;
            ndb = m_db;
            for (int i = 0; i < 5; i++) begin
                if (syn[i] != m_db[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DB) begin
                        ndb[i] = ~m_db[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_rise2 = m_rise1;
            m_rise1 = ndb & ~m_db;
            m_raw2 = m_raw1;
            m_raw1 = rawv;
            m_db = ndb;
        end
    end

    always @(posedge clk) edge_n++;

    always @(negedge clk) begin : compare
        logic [4:0] outs;
        outs = {bus.butc, bus.butr, bus.butl, bus.butd, bus.butu};
        check("pulses", outs, m_pulse);
        check("btn_code", bus.btn_code, m_code);
        check("busy", bus.busy, m_busy);
        check("dropped", bus.dropped, m_drop);
        for (int i = 0; i < 5; i++) begin
            if (outs[i]) begin
                pcnt[i]++;
                last_edge[i] = edge_n;
            end
        end
        if (bus.dropped) dcnt++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic handler_done();
        bus.irq_done = 1'b1;
        step(1);
        bus.irq_done = 1'b0;
    endtask

    initial begin
        int e, base, base2, d0;
        bus.btn_u_raw = 0; bus.btn_d_raw = 0; bus.btn_l_raw = 0;
        bus.btn_r_raw = 0; bus.btn_c_raw = 0; bus.irq_done = 0;
        step(3);
        check("rst_busy", bus.busy, 0);
        check("rst_code", bus.btn_code, 0);
        check("rst_dropped", bus.dropped, 0);
        check("rst_butu", bus.butu, 0);
        rst = 1'b0;
        step(3);

        // single press
        e = edge_n + 1;
        bus.btn_u_raw = 1;
        step(12);
        check("single_edge", last_edge[0], e + DB + 3);
        check("single_count", pcnt[0], 1);
        check("single_code", bus.btn_code, 1);
        check("single_busy", bus.busy, 1);
        handler_done();
        bus.btn_u_raw = 0;
        step(15);
        check("single_idle", bus.busy, 0);

        // bounce
        base = pcnt[4];
        d0 = dcnt;
        for (int i = 0; i < 10; i++) begin
            bus.btn_c_raw = 1; step(2);
            bus.btn_c_raw = 0; step(2);
        end
        step(12);
        check("bounce_pulses", pcnt[4] - base, 0);
        check("bounce_dropped", dcnt - d0, 0);
        check("bounce_busy", bus.busy, 0);

        // simultaneous press
        base = pcnt[2];
        base2 = pcnt[3];
        bus.btn_l_raw = 1; bus.btn_r_raw = 1;
        step(12);
        check("simul_l", pcnt[2] - base, 1);
        check("simul_r", pcnt[3] - base2, 0);
        check("simul_code", bus.btn_code, 3);
        handler_done();
        bus.btn_l_raw = 0; bus.btn_r_raw = 0;
        step(15);
        check("simul_idle", bus.busy, 0);
        check("simul_r_after", pcnt[3] - base2, 0);

        // busy press
        base = pcnt[1];
        d0 = dcnt;
        bus.btn_u_raw = 1;
        step(12);
        check("busy_u_code", bus.btn_code, 1);
        bus.btn_d_raw = 1;
        step(12);
        check("busy_drop", dcnt - d0, PEND ? 0 : 1);
        check("busy_d_early", pcnt[1] - base, 0);
        handler_done();
        bus.btn_u_raw = 0; bus.btn_d_raw = 0;
        step(15);
        check("busy_d_issued", pcnt[1] - base, PEND ? 1 : 0);
        check("busy_code", bus.btn_code, PEND ? 2 : 1);
        handler_done();
        step(12);
        check("busy_idle", bus.busy, 0);
        check("busy_drop_total", dcnt - d0, PEND ? 0 : 1);

        // reset mid-request
        bus.btn_u_raw = 1;
        step(12);
        check("rstmid_busy_before", bus.busy, 1);
        #2 rst = 1'b1;
        #1;
        check("rstmid_busy", bus.busy, 0);
        check("rstmid_code", bus.btn_code, 0);
        step(3);
        rst = 1'b0;
        e = edge_n + 1;
        step(12);
        check("rstmid_edge", last_edge[0], e + DB + 3);
        check("rstmid_code_after", bus.btn_code, 1);
        handler_done();
        bus.btn_u_raw = 0;
        step(15);
        check("rstmid_idle", bus.busy, 0);

        // stuck button
        base = pcnt[3];
        bus.btn_r_raw = 1;
        step(12);
        handler_done();
        step(15);
        check("stuck_busy", bus.busy, 1);
        check("stuck_count", pcnt[3] - base, 1);
        check("stuck_code", bus.btn_code, 4);
        bus.btn_r_raw = 0;
        step(12);
        check("stuck_idle", bus.busy, 0);
        check("stuck_count_after", pcnt[3] - base, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
